ones_serializer: RTL and testbench

Transmit-side counterpart to the combinational ones-counter. It accepts a ones count over a valid/ready handshake and emits a DATA_WIDTH-bit serial frame, one bit per accepted beat, that contains exactly that many ones. The ones form a thermometer pattern: bits 0..count-1 are 1 and the rest are 0. A downstream ones-counter fed by a deserializer therefore recovers the original count, which makes this block the stimulus/loopback source for count-based links and self-checks.

---
 rtl/ones_serializer.sv | 101 ++++++++++
 tb/tb_ones_serializer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ones_serializer.sv
// ones_serializer: emits a DATA_WIDTH-beat thermometer frame holding a requested number of ones
//
// Ports:
//   clk, reset             clock and asynchronous active-high reset
//   din, din_valid         requested ones count and its valid (handshake with din_ready)
//   din_ready              count accepted this cycle; also high on a handshaked last beat
//   dout, dout_valid       current frame bit and its valid (handshake with dout_ready)
//   dout_last              dout is the final bit of the frame
//   dout_ready             downstream accepts dout
//   busy                   frame in progress (same as dout_valid)
//   mask_out, mask_valid   assembled frame plus one-cycle strobe; present only when
//                          ONES_SERIALIZER_MASK_EN is defined
module ones_serializer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [$clog2(DATA_WIDTH):0] din,
    input  logic                        din_valid,
    output logic                        din_ready,
    output logic                        dout,
    output logic                        dout_valid,
    output logic                        dout_last,
    input  logic                        dout_ready,
    output logic                        busy
`ifdef ONES_SERIALIZER_MASK_EN
    ,
    output logic [DATA_WIDTH-1:0]       mask_out,
    output logic                        mask_valid
`endif
);
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state;
    logic [CW-1:0] cnt, idx, idx_nx, din_sat;

    assign idx_nx  = idx + 1'b1;
    assign din_sat = (din > CW'(DATA_WIDTH)) ? CW'(DATA_WIDTH) : din;
    // A handshaked last beat frees the slot in the same cycle, giving gapless frames.
    assign din_ready = (state == IDLE) || (dout_last && dout_ready);
    assign busy      = dout_valid;

    // dout/dout_last are registered, so each update precomputes them for the next index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else if (din_valid && din_ready) begin
            state      <= SEND;
            cnt        <= din_sat;
            idx        <= '0;
            dout       <= (din_sat != '0);
            dout_valid <= 1'b1;
            dout_last  <= 1'b0;
        end else if (state == SEND && dout_ready) begin
            if (dout_last) begin
                state      <= IDLE;
                idx        <= '0;
                dout       <= 1'b0;
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
            end else begin
                idx       <= idx_nx;
                dout      <= (idx_nx < cnt);
                dout_last <= (idx_nx == CW'(DATA_WIDTH - 1));
            end
        end
    end

`ifdef ONES_SERIALIZER_MASK_EN
    localparam int IW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] frame, frame_nx;

    always_comb begin
        frame_nx = frame;
        frame_nx[idx[IW-1:0]] = dout;
    end

    // Publishing frame_nx lets the final beat land in mask_out together with the strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame      <= '0;
            mask_out   <= '0;
            mask_valid <= 1'b0;
        end else begin
            mask_valid <= dout_valid && dout_ready && dout_last;
            if (dout_valid && dout_ready)
                frame <= frame_nx;
            if (dout_valid && dout_ready && dout_last)
                mask_out <= frame_nx;
        end
    end
`endif
endmodule

// File: tb/tb_ones_serializer.sv
// tb_ones_serializer: scoreboard bench for ones_serializer with directed frames
module tb_ones_serializer;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [4:0]   din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic         dout, dout_valid, dout_last;
    logic         dout_ready = 1'b1;
    logic         busy;
`ifdef ONES_SERIALIZER_MASK_EN
    logic [W-1:0] mask_out;
    logic         mask_valid;
    logic [W-1:0] mq[$];
`endif

    logic [1:0]   sq[$];
    int           tests = 0;
    int           failed = 0;
    int           run = 0;
    int           max_run = 0;
    bit           stall_prev = 1'b0;
    logic         prev_dout, prev_last;

    ones_serializer #(.DATA_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last), .dout_ready(dout_ready),
        .busy(busy)
`ifdef ONES_SERIALIZER_MASK_EN
        , .mask_out(mask_out), .mask_valid(mask_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one pop per output handshake, plus hold checks across stalls.
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
            run = 0;
        end else begin
            chk("busy_eq_valid", busy, dout_valid);
            run = dout_valid ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (stall_prev && dout_valid) begin
                chk("stall_hold_dout", dout, prev_dout);
                chk("stall_hold_last", dout_last, prev_last);
            end
            if (dout_valid && dout_ready) begin
                if (sq.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    logic [1:0] e;
                    e = sq.pop_front();
                    chk("dout", dout, e[0]);
                    chk("dout_last", dout_last, e[1]);
                end
            end
`ifdef ONES_SERIALIZER_MASK_EN
            if (mask_valid) begin
                if (mq.size() == 0) chk("unexpected_mask", 1, 0);
                else chk("mask_out", mask_out, mq.pop_front());
            end
`endif
            stall_prev = dout_valid && !dout_ready;
            prev_dout = dout;
            prev_last = dout_last;
        end
    end

    // Offer a count, push the expected frame at the handshake, optionally keep din_valid high.
    task automatic send(input int n, input bit hold);
        int c = 0;
        int ones;
        din = 5'(n);
        din_valid = 1'b1;
        @(negedge clk);
        while (!din_ready && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("din_ready_timeout", c < 200, 1);
        ones = (n > W) ? W : n;
        for (int i = 0; i < W; i++) sq.push_back({1'(i == W - 1), 1'(i < ones)});
`ifdef ONES_SERIALIZER_MASK_EN
        mq.push_back(W'((32'd1 << ones) - 1));
`endif
        @(posedge clk);
        #1;
        chk("first_beat_valid", dout_valid, 1);
        if (!hold) din_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((dout_valid || sq.size() != 0) && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("idle_timeout", c < 300, 1);
        chk("din_ready_after_frame", din_ready, 1);
        chk("queue_drained", sq.size(), 0);
    endtask

    initial begin
        bit [3:0] pat = 4'b1001;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_din_ready", din_ready, 1);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dout_last", dout_last, 0);
        chk("rst_busy", busy, 0);
`ifdef ONES_SERIALIZER_MASK_EN
        chk("rst_mask_out", mask_out, 0);
        chk("rst_mask_valid", mask_valid, 0);
`endif
        send(5, 0);  wait_idle();
        send(0, 0);  wait_idle();
        send(16, 0); wait_idle();
        send(20, 0); wait_idle();
        send(31, 0); wait_idle();
`ifdef ONES_SERIALIZER_MASK_EN
        send(4, 0);  wait_idle();
`endif

        send(3, 0);
        for (int k = 0; k < 200 && dout_valid; k++) begin
            dout_ready = pat[k % 4];
            @(posedge clk);
            #1;
        end
        dout_ready = 1'b1;
        wait_idle();

        max_run = 0;
        send(7, 1);
        send(2, 0);
        wait_idle();
        chk("gapless_run", max_run, 2 * W);

        send(9, 0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_dout_valid", dout_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_dout", dout, 0);
        chk("rst_mid_din_ready", din_ready, 1);
        chk("rst_mid_beats_left", sq.size(), W - 4);
        sq.delete();
`ifdef ONES_SERIALIZER_MASK_EN
        mq.delete();
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(1, 0);
        wait_idle();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
